// File: rtl/jbi_ncio_mack_pkg.sv
// jbi_ncio_mack_pkg: shared constants for the ncio mondo-ack controller.
// Holds the default ADDR_W/ID_W/TO_W, the MAKQ entry bit layout
// {agtid, cpuid, nack, resolved}, and the one-hot pop-FSM encodings.
package jbi_ncio_mack_pkg;

    localparam int JBI_ADDR_W = 4;
    localparam int JBI_ID_W   = 5;
    localparam int JBI_TO_W   = 10;

    localparam int MAKQ_RES_BIT  = 0;
    localparam int MAKQ_NACK_BIT = 1;
    localparam int MAKQ_CPUID_LO = 2;
    localparam int MAKQ_CPUID_HI = MAKQ_CPUID_LO + JBI_ID_W - 1;
    localparam int MAKQ_AGTID_LO = MAKQ_CPUID_HI + 1;
    localparam int MAKQ_AGTID_HI = MAKQ_AGTID_LO + JBI_ID_W - 1;
    localparam int MAKQ_ENT_W    = MAKQ_AGTID_HI + 1;

    localparam int ST_IDLE_B = 0;
    localparam int ST_REQ_B  = 1;
    localparam int ST_HDR0_B = 2;
    localparam int ST_HDR1_B = 3;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_REQ  = 4'b0010,
        ST_HDR0 = 4'b0100,
        ST_HDR1 = 4'b1000
    } mack_state_e;

endpackage

// File: rtl/jbi_ncio_mack_if.sv
// jbi_ncio_mack_if: MAKQ push side, IOB responses and the outbound JBus
// header port of the mondo-ack controller.
// slave modport: the controller; master modport: the surrounding logic.
// mack_timeout exists only when JBI_MACK_TIMEOUT_EN is defined.
interface jbi_ncio_mack_if #(
    parameter int ADDR_W = jbi_ncio_mack_pkg::JBI_ADDR_W,
    parameter int ID_W   = jbi_ncio_mack_pkg::JBI_ID_W
);
    logic              makq_push;
    logic [2*ID_W-1:0] makq_wdata;
    logic              makq_nack;
    logic              iob_jbi_mondo_ack_ff;
    logic              iob_jbi_mondo_nack_ff;
    logic              mack_gnt;
    logic              mack_req;
    logic              mack_vld;
    logic              mack_last;
    logic              mack_nack;
    logic [ID_W-1:0]   mack_agtid;
    logic [ID_W-1:0]   mack_cpuid;
    logic              makq_full;
    logic [ADDR_W:0]   makq_level;
    logic              makq_ovf;
    logic              mack_proto_err;
`ifdef JBI_MACK_TIMEOUT_EN
    logic              mack_timeout;
`endif

    modport slave (
        input  makq_push, makq_wdata, makq_nack,
        input  iob_jbi_mondo_ack_ff, iob_jbi_mondo_nack_ff, mack_gnt,
        output mack_req, mack_vld, mack_last, mack_nack, mack_agtid, mack_cpuid,
        output makq_full, makq_level, makq_ovf, mack_proto_err
`ifdef JBI_MACK_TIMEOUT_EN
        , output mack_timeout
`endif
    );

    modport master (
        output makq_push, makq_wdata, makq_nack,
        output iob_jbi_mondo_ack_ff, iob_jbi_mondo_nack_ff, mack_gnt,
        input  mack_req, mack_vld, mack_last, mack_nack, mack_agtid, mack_cpuid,
        input  makq_full, makq_level, makq_ovf, mack_proto_err
`ifdef JBI_MACK_TIMEOUT_EN
        , input mack_timeout
`endif
    );

endinterface

// File: rtl/jbi_ncio_mack_fifo.sv
// jbi_ncio_mack_fifo: MAKQ storage with wrap-bit pointers and a
// resolve-by-index write port.
// Ports: clk/rst; push/wdata/wr_res enqueue (dropped when full); pop retires
// the head; res_en/res_idx/res_nack resolve one stored entry; full/level/wptr
// status; head_* fields of the head entry; nxt_rdy says whether the entry
// that will be at the head next cycle is present and resolved, including
// this cycle's push, resolve and pop.
module jbi_ncio_mack_fifo
    import jbi_ncio_mack_pkg::*;
#(
    parameter int ADDR_W = JBI_ADDR_W,
    parameter int ID_W   = JBI_ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [2*ID_W-1:0] wdata,
    input  logic              wr_res,
    input  logic              pop,
    input  logic              res_en,
    input  logic [ADDR_W-1:0] res_idx,
    input  logic              res_nack,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W:0]   wptr,
    output logic              nxt_rdy,
    output logic [ID_W-1:0]   head_agtid,
    output logic [ID_W-1:0]   head_cpuid,
    output logic              head_nack
);
    logic [MAKQ_ENT_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W:0]       rptr, nptr;
    logic [ADDR_W-1:0]     widx, ridx, nidx;
    logic                  wr_en;

    assign widx  = wptr[ADDR_W-1:0];
    assign ridx  = rptr[ADDR_W-1:0];
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) && (widx == ridx);
    assign wr_en = push & ~full;
    assign level = wptr - rptr;
    assign nptr  = rptr + (ADDR_W+1)'(pop);
    assign nidx  = nptr[ADDR_W-1:0];

    // An empty slot may hold a stale resolved bit, so when the next head is
    // the write slot only this cycle's push can make it ready.
    assign nxt_rdy = (nptr != wptr) ? (mem[nidx][MAKQ_RES_BIT] | (res_en & (res_idx == nidx)))
                                    : (wr_en & wr_res);

    assign head_agtid = mem[ridx][MAKQ_AGTID_HI:MAKQ_AGTID_LO];
    assign head_cpuid = mem[ridx][MAKQ_CPUID_HI:MAKQ_CPUID_LO];
    assign head_nack  = mem[ridx][MAKQ_NACK_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (ADDR_W+1)'(wr_en);
            rptr <= nptr;
        end
    end

    // A pre-nacked entry is written with nack and resolved both set.
    always_ff @(posedge clk) begin
        if (wr_en) mem[widx] <= {wdata, wr_res, wr_res};
        if (res_en) begin
            mem[res_idx][MAKQ_NACK_BIT] <= res_nack;
            mem[res_idx][MAKQ_RES_BIT]  <= 1'b1;
        end
    end

endmodule

// File: rtl/jbi_ncio_mack_ctl.sv
// jbi_ncio_mack_ctl: mondo ack controller; tracks the single pending mondo,
// resolves it from IOB ack/nack, and sends resolved MAKQ entries in FIFO
// order as two-cycle INT_ACK/INT_NACK headers after an arbiter grant.
// Ports: clk, rst (async, active high); bus (jbi_ncio_mack_if.slave) carries
// push/IOB/grant inputs and req/header/status outputs.
// Optional: JBI_MACK_TIMEOUT_EN adds a TO_W-bit pending timeout that forces
// a nack and pulses bus.mack_timeout.
module jbi_ncio_mack_ctl
    import jbi_ncio_mack_pkg::*;
#(
    parameter int ADDR_W = JBI_ADDR_W,
    parameter int ID_W   = JBI_ID_W,
    parameter int TO_W   = JBI_TO_W
) (
    input logic            clk,
    input logic            rst,
    jbi_ncio_mack_if.slave bus
);
    mack_state_e       state, state_nxt;
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W-1:0] pend_ptr;
    logic [ID_W-1:0]   head_agtid, head_cpuid, hdr_agtid, hdr_cpuid;
    logic              head_nack, hdr_nack, full, nxt_rdy, pend_vld;
    logic              rsp, pend_push, to_hit, res_en, res_nack, ovf_q, perr_q;

    assign rsp       = bus.iob_jbi_mondo_ack_ff | bus.iob_jbi_mondo_nack_ff;
    assign pend_push = bus.makq_push & ~bus.makq_nack & ~full;
    // Only the old pending entry is ever resolved; a response beats the
    // forced nack of a second pending push, and nack beats ack.
    assign res_en    = pend_vld & (rsp | pend_push | to_hit);
    assign res_nack  = rsp ? bus.iob_jbi_mondo_nack_ff : 1'b1;

    jbi_ncio_mack_fifo #(.ADDR_W(ADDR_W), .ID_W(ID_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (bus.makq_push),
        .wdata      (bus.makq_wdata),
        .wr_res     (bus.makq_nack),
        .pop        (state[ST_HDR1_B]),
        .res_en     (res_en),
        .res_idx    (pend_ptr),
        .res_nack   (res_nack),
        .full       (full),
        .level      (bus.makq_level),
        .wptr       (wptr),
        .nxt_rdy    (nxt_rdy),
        .head_agtid (head_agtid),
        .head_cpuid (head_cpuid),
        .head_nack  (head_nack)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: state_nxt = nxt_rdy ? ST_REQ : ST_IDLE;
            ST_REQ:  state_nxt = bus.mack_gnt ? ST_HDR0 : ST_REQ;
            ST_HDR0: state_nxt = ST_HDR1;
            ST_HDR1: state_nxt = nxt_rdy ? ST_REQ : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend_vld  <= 1'b0;
            pend_ptr  <= '0;
            hdr_nack  <= 1'b0;
            hdr_agtid <= '0;
            hdr_cpuid <= '0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_vld <= pend_push | (pend_vld & ~res_en);
            if (pend_push) pend_ptr <= wptr[ADDR_W-1:0];
            if (state[ST_REQ_B] && bus.mack_gnt) {hdr_nack, hdr_agtid, hdr_cpuid} <= {head_nack, head_agtid, head_cpuid};
            ovf_q  <= bus.makq_push & full;
            perr_q <= (rsp & ~pend_vld) | (pend_push & pend_vld);
        end
    end

`ifdef JBI_MACK_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_q;

    assign to_hit = pend_vld & (&to_cnt) & ~rsp & ~pend_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            to_cnt <= pend_push ? '0 : (pend_vld ? to_cnt + TO_W'(1) : to_cnt);
            to_q   <= to_hit;
        end
    end

    assign bus.mack_timeout = to_q;
`else
    assign to_hit = 1'b0;
`endif

    assign bus.mack_req       = state[ST_REQ_B];
    assign bus.mack_vld       = state[ST_HDR0_B] | state[ST_HDR1_B];
    assign bus.mack_last      = state[ST_HDR1_B];
    assign bus.mack_nack      = hdr_nack;
    assign bus.mack_agtid     = hdr_agtid;
    assign bus.mack_cpuid     = hdr_cpuid;
    assign bus.makq_full      = full;
    assign bus.makq_ovf       = ovf_q;
    assign bus.mack_proto_err = perr_q;

endmodule

// File: tb/tb_jbi_ncio_mack_ctl.sv
// tb_jbi_ncio_mack_ctl: scoreboard bench for jbi_ncio_mack_ctl; directed
// scenarios plus random traffic against a queue-based reference model.
module tb_jbi_ncio_mack_ctl;
    import jbi_ncio_mack_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jbi_ncio_mack_if bus ();
    jbi_ncio_mack_ctl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int agt;
        int cpu;
        bit nk;
        bit rs;
    } ent_t;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    bit   pv, ovf_e, perr_e, to_e, hrdy, popnow, mf, ok, rsp, pp;
    int   pseq, hseq, pstart, cyc, hstage, nh;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks outputs of the current cycle against the model, then
    // advances the model with the inputs applied in this cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pv = 0; ovf_e = 0; perr_e = 0; to_e = 0;
            hseq = 0; hstage = 0; cyc = 0;
        end else begin
            cyc++;
            chk("level", int'(bus.makq_level), q.size());
            chk("full", int'(bus.makq_full), int'(q.size() == 16));
            chk("ovf", int'(bus.makq_ovf), int'(ovf_e));
            chk("proto_err", int'(bus.mack_proto_err), int'(perr_e));
`ifdef JBI_MACK_TIMEOUT_EN
            chk("timeout", int'(bus.mack_timeout), int'(to_e));
`endif
            hrdy = q.size() > 0 && q[0].rs;
            if (!bus.mack_vld) chk("req", int'(bus.mack_req), int'(hrdy));
            else chk("req_in_hdr", int'(bus.mack_req), 0);
            if (hstage == 0) chk("vld_idle", int'(bus.mack_vld), 0);
            else begin
                chk("vld", int'(bus.mack_vld), 1);
                chk("last", int'(bus.mack_last), int'(hstage == 2));
                chk("hdr_head_present", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    chk("hdr_resolved", int'(q[0].rs), 1);
                    chk("hdr_nack", int'(bus.mack_nack), int'(q[0].nk));
                    chk("hdr_agtid", int'(bus.mack_agtid), q[0].agt);
                    chk("hdr_cpuid", int'(bus.mack_cpuid), q[0].cpu);
                end
            end
            popnow = hstage == 2;
            nh = (hstage == 0 && bus.mack_req && bus.mack_gnt) ? 1 : (hstage == 1 ? 2 : 0);
            mf = q.size() == 16;
            ok = bus.makq_push && !mf;
            rsp = bus.iob_jbi_mondo_ack_ff || bus.iob_jbi_mondo_nack_ff;
            pp = ok && !bus.makq_nack;
            ovf_e = bus.makq_push && mf;
            perr_e = (rsp && !pv) || (pp && pv);
            to_e = 0;
            if (pv && (rsp || pp)) begin
                q[pseq - hseq].nk = rsp ? bus.iob_jbi_mondo_nack_ff : 1'b1;
                q[pseq - hseq].rs = 1;
                pv = 0;
            end
`ifdef JBI_MACK_TIMEOUT_EN
            else if (pv && cyc - pstart == 1024) begin
                q[pseq - hseq].nk = 1;
                q[pseq - hseq].rs = 1;
                pv = 0;
                to_e = 1;
            end
`endif
            if (ok) begin
                if (pp) begin
                    pv = 1;
                    pseq = hseq + q.size();
                    pstart = cyc;
                end
                q.push_back('{int'(bus.makq_wdata[9:5]), int'(bus.makq_wdata[4:0]), bus.makq_nack, bus.makq_nack});
            end
            if (popnow && q.size() > 0) begin
                void'(q.pop_front());
                hseq++;
            end
            hstage = nh;
        end
    end

    task automatic drive(input bit p, input logic [9:0] wd, input bit pn, input bit a, input bit n, input bit g);
        bus.makq_push = p;
        bus.makq_wdata = wd;
        bus.makq_nack = pn;
        bus.iob_jbi_mondo_ack_ff = a;
        bus.iob_jbi_mondo_nack_ff = n;
        bus.mack_gnt = g;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cnt, input bit g);
        for (int i = 0; i < cnt; i++) drive(0, 10'd0, 0, 0, 0, g);
    endtask

    initial begin
        int tcount;
        bit hit;
        bus.makq_push = 0; bus.makq_wdata = '0; bus.makq_nack = 0;
        bus.iob_jbi_mondo_ack_ff = 0; bus.iob_jbi_mondo_nack_ff = 0; bus.mack_gnt = 0;
        #12;
        chk("rst_req", int'(bus.mack_req), 0);
        chk("rst_vld", int'(bus.mack_vld), 0);
        chk("rst_last", int'(bus.mack_last), 0);
        chk("rst_nack", int'(bus.mack_nack), 0);
        chk("rst_agtid", int'(bus.mack_agtid), 0);
        chk("rst_cpuid", int'(bus.mack_cpuid), 0);
        chk("rst_full", int'(bus.makq_full), 0);
        chk("rst_level", int'(bus.makq_level), 0);
        chk("rst_ovf", int'(bus.makq_ovf), 0);
        chk("rst_perr", int'(bus.mack_proto_err), 0);
        @(posedge clk);
        #1 rst = 0;
        idle(2, 0);
        // Pre-nacked entry, grant three cycles after the push.
        drive(1, {5'd3, 5'd9}, 1, 0, 0, 0);
        idle(2, 0);
        drive(0, 10'd0, 0, 0, 0, 1);
        idle(5, 0);
        // Pending entry acked, then one nacked, 20 cycles later.
        drive(1, {5'd1, 5'd2}, 0, 0, 0, 1);
        idle(20, 1);
        drive(0, 10'd0, 0, 1, 0, 1);
        idle(5, 1);
        drive(1, {5'd1, 5'd2}, 0, 0, 0, 1);
        idle(20, 1);
        drive(0, 10'd0, 0, 0, 1, 1);
        idle(5, 1);
        // Pending A blocks pre-nacked B until A resolves.
        drive(1, {5'd10, 5'd11}, 0, 0, 0, 1);
        drive(1, {5'd12, 5'd13}, 1, 0, 0, 1);
        idle(6, 1);
        drive(0, 10'd0, 0, 1, 0, 1);
        idle(10, 1);
        // Fill to full, overflow, then drain through the pointer wrap.
        for (int i = 0; i < 16; i++) drive(1, 10'(i * 33 + 1), 1, 0, 0, 0);
        chk("full_after_16", int'(bus.makq_full), 1);
        chk("level_after_16", int'(bus.makq_level), 16);
        drive(1, 10'd1023, 1, 0, 0, 0);
        chk("level_after_ovf", int'(bus.makq_level), 16);
        chk("ovf_pulse", int'(bus.makq_ovf), 1);
        idle(70, 1);
        chk("level_drained", int'(bus.makq_level), 0);
        // Orphan ack, then ack and nack together on a pending entry.
        drive(0, 10'd0, 0, 1, 0, 1);
        chk("orphan_perr", int'(bus.mack_proto_err), 1);
        drive(1, {5'd4, 5'd5}, 0, 0, 0, 1);
        idle(3, 1);
        drive(0, 10'd0, 0, 1, 1, 1);
        idle(6, 1);
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 2) == 0, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  i < 1500 ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1)));
        drive(0, 10'd0, 0, 1, 0, 1);
        idle(150, 1);
        chk("level_final_drain", int'(bus.makq_level), 0);
`ifdef JBI_MACK_TIMEOUT_EN
        tcount = 0;
        drive(1, {5'd7, 5'd6}, 0, 0, 0, 1);
        for (int i = 0; i < 1100; i++) begin
            drive(0, 10'd0, 0, 0, 0, 1);
            tcount += int'(bus.mack_timeout);
        end
        chk("timeout_pulses", tcount, 1);
        chk("level_after_timeout", int'(bus.makq_level), 0);
`endif
        // Reset asserted while the first header cycle is on the bus.
        hit = 0;
        drive(1, {5'd2, 5'd8}, 1, 0, 0, 1);
        for (int i = 0; i < 20 && !hit; i++) begin
            drive(0, 10'd0, 0, 0, 0, 1);
            hit = bus.mack_vld && !bus.mack_last;
        end
        chk("hdr0_reached", int'(hit), 1);
        rst = 1;
        #1;
        chk("rst_mid_vld", int'(bus.mack_vld), 0);
        chk("rst_mid_level", int'(bus.makq_level), 0);
        chk("rst_mid_req", int'(bus.mack_req), 0);
        idle(3, 0);
        rst = 0;
        idle(5, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
